pwm_multi: RTL and testbench

- Multi-channel PWM generator. One shared free-running period counter drives CH independent compare channels.
- Each channel has its own start/end thresholds and polarity.
- Settings are double-buffered: a load strobe captures new values, and they take effect only at the period boundary, so no glitched pulses occur.
- Sits between a register interface and the motor/LED driver pins; successor to the single-channel fixed-2^N pwm.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_channel.sv | 56 +++++
 rtl/pwm_multi.sv | 90 +++++++++
 tb/tb_pwm_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
// Channel i occupies bits [ch_lo(i, N) +: N] of the packed threshold buses.
package pwm_pkg;

   localparam int CNT_W  = 8;
   localparam int CH_DEF = 4;

   function automatic int ch_lo(input int i, input int n);
      return i * n;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One compare channel: active start/end/polarity, window compare
// and the registered output pin.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int N = CNT_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         apply,
   input  logic [N-1:0] cnt,
   input  logic [N-1:0] start_nxt,
   input  logic [N-1:0] end_nxt,
   input  logic         pol_nxt,
   output logic         out_pwm
);

   logic [N-1:0] act_start;
   logic [N-1:0] act_end;
   logic         act_pol;
   logic         raw;

   // start > end is a window that straddles the wrap to zero
   always_comb begin
      raw = 1'b0;
      unique case (1'b1)
         (act_start < act_end):
            raw = (cnt >= act_start) && (cnt < act_end);
         (act_start > act_end):
            raw = (cnt >= act_start) || (cnt < act_end);
         default:
            raw = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         act_start <= '0;
         act_end   <= '0;
         act_pol   <= 1'b0;
         out_pwm   <= 1'b0;
      end else begin
         if (apply) begin
            act_start <= start_nxt;
            act_end   <= end_nxt;
            act_pol   <= pol_nxt;
         end
         if (enable)
            out_pwm <= raw ^ act_pol;
         else
            out_pwm <= act_pol;
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, double-buffered settings
// that switch over only at the period boundary.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int N  = CNT_W,
   parameter int CH = CH_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic [N-1:0]  period,
   input  logic [CH*N-1:0] dataHighStart,
   input  logic [CH*N-1:0] dataHighEnd,
   input  logic [CH-1:0] polarity,
   input  logic          load,
   output logic [CH-1:0] out_pwm,
   output logic          periodStart,
   output logic          updateDone,
   output logic          pending
);

   logic [N-1:0]    cnt;
   logic [N-1:0]    act_period;
   logic [N-1:0]    pend_period;
   logic [CH*N-1:0] pend_start;
   logic [CH*N-1:0] pend_end;
   logic [CH-1:0]   pend_pol;

   logic            boundary;
   logic            apply;
   logic [N-1:0]    nxt_period;
   logic [CH*N-1:0] nxt_start;
   logic [CH*N-1:0] nxt_end;
   logic [CH-1:0]   nxt_pol;

   assign boundary = enable && (cnt == act_period);
   assign apply    = boundary && (load || pending);

   // a load landing on the boundary bypasses the pending stage
   assign nxt_period = load ? period        : pend_period;
   assign nxt_start  = load ? dataHighStart : pend_start;
   assign nxt_end    = load ? dataHighEnd   : pend_end;
   assign nxt_pol    = load ? polarity      : pend_pol;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         act_period  <= '0;
         pend_period <= '0;
         pend_start  <= '0;
         pend_end    <= '0;
         pend_pol    <= '0;
         pending     <= 1'b0;
         periodStart <= 1'b0;
         updateDone  <= 1'b0;
      end else begin
         if (enable)
            cnt <= boundary ? '0 : cnt + N'(1);
         periodStart <= boundary;
         updateDone  <= apply;
         if (apply)
            act_period <= nxt_period;
         if (load && !boundary) begin
            pend_period <= period;
            pend_start  <= dataHighStart;
            pend_end    <= dataHighEnd;
            pend_pol    <= polarity;
            pending     <= 1'b1;
         end else if (boundary) begin
            pending <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      pwm_channel #(.N(N)) u_ch (
         .clock     (clock),
         .reset     (reset),
         .enable    (enable),
         .apply     (apply),
         .cnt       (cnt),
         .start_nxt (nxt_start[ch_lo(i, N) +: N]),
         .end_nxt   (nxt_end[ch_lo(i, N) +: N]),
         .pol_nxt   (nxt_pol[i]),
         .out_pwm   (out_pwm[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (N=8, CH=2); per-scenario tasks with
// hand-computed expectations, sampled on the falling edge.
module tb_pwm_multi;

   localparam int N  = 8;
   localparam int CH = 2;

   logic          clock;
   logic          reset;
   logic          enable;
   logic [N-1:0]  period;
   logic [CH*N-1:0] dataHighStart;
   logic [CH*N-1:0] dataHighEnd;
   logic [CH-1:0] polarity;
   logic          load;
   logic [CH-1:0] out_pwm;
   logic          periodStart;
   logic          updateDone;
   logic          pending;

   int vectors;
   int miscompares;
   int waited;
   int hi0, hi1, fh0, fh1, fl0, fl1;

   pwm_multi #(.N(N), .CH(CH)) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .period        (period),
      .dataHighStart (dataHighStart),
      .dataHighEnd   (dataHighEnd),
      .polarity      (polarity),
      .load          (load),
      .out_pwm       (out_pwm),
      .periodStart   (periodStart),
      .updateDone    (updateDone),
      .pending       (pending)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic do_load(input logic [7:0] p,
                          input logic [7:0] s0, input logic [7:0] e0,
                          input logic [7:0] s1, input logic [7:0] e1,
                          input logic [1:0] pol);
      period        = p;
      dataHighStart = {s1, s0};
      dataHighEnd   = {e1, e0};
      polarity      = pol;
      load          = 1'b1;
      @(negedge clock);
      load          = 1'b0;
   endtask

   task automatic wait_ps(input int limit);
      waited = 0;
      do begin
         @(negedge clock);
         waited++;
      end while (!periodStart && waited < limit);
      if (!periodStart) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_ps: periodStart not seen within %0d cycles", limit);
      end
   endtask

   task automatic skip(input int n);
      for (int k = 0; k < n; k++) @(negedge clock);
   endtask

   // samples j=1..len after a periodStart sample; sample j shows cnt j-1
   task automatic measure(input int len);
      hi0 = 0; hi1 = 0; fh0 = -1; fh1 = -1; fl0 = -1; fl1 = -1;
      for (int j = 1; j <= len; j++) begin
         @(negedge clock);
         if (out_pwm[0]) begin
            hi0++;
            if (fh0 < 0) fh0 = j;
         end else if (fl0 < 0) fl0 = j;
         if (out_pwm[1]) begin
            hi1++;
            if (fh1 < 0) fh1 = j;
         end else if (fl1 < 0) fl1 = j;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b0; load = 1'b0;
      period = '0; dataHighStart = '0; dataHighEnd = '0; polarity = '0;
      skip(3);
      vectors++;
      if ({out_pwm, periodStart, updateDone, pending} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_state: got %b expected 00000",
                  {out_pwm, periodStart, updateDone, pending});
      end
      reset = 1'b0;
      enable = 1'b1;
      skip(2);
      chk("idle_period_start", periodStart, 1);
   endtask

   task automatic test_basic;
      do_load(8'd255, 8'd50, 8'd60, 8'd50, 8'd150, 2'b00);
      chk("basic_bypass_ps", periodStart, 1);
      chk("basic_bypass_ud", updateDone, 1);
      chk("basic_bypass_pend", pending, 0);
      measure(256);
      chk("basic_hi0", hi0, 10);
      chk("basic_hi1", hi1, 100);
      chk("basic_rise0", fh0, 51);
      chk("basic_rise1", fh1, 51);
      chk("basic_ps_256", periodStart, 1);
   endtask

   task automatic test_wrap;
      do_load(8'd255, 8'd60, 8'd50, 8'd0, 8'd45, 2'b00);
      chk("wrap_pending", pending, 1);
      chk("wrap_ud_early", updateDone, 0);
      wait_ps(300);
      chk("wrap_wait", waited, 255);
      chk("wrap_ud", updateDone, 1);
      chk("wrap_pend_clr", pending, 0);
      measure(256);
      chk("wrap_hi0", hi0, 246);
      chk("wrap_low0", fl0, 51);
      chk("wrap_hi1", hi1, 45);
      chk("wrap_rise1", fh1, 1);
      chk("wrap_ud_once", updateDone, 0);
   endtask

   task automatic test_corner;
      do_load(8'd255, 8'd20, 8'd20, 8'd20, 8'd20, 2'b10);
      wait_ps(300);
      measure(256);
      chk("eq_zero_duty", hi0, 0);
      chk("eq_pol_full", hi1, 256);
   endtask

   task automatic test_shadow;
      int bad0, bad1, badp;
      skip(100);
      do_load(8'd255, 8'd10, 8'd20, 8'd0, 8'd0, 2'b00);
      chk("shadow_pending", pending, 1);
      skip(49);
      do_load(8'd255, 8'd30, 8'd40, 8'd0, 8'd45, 2'b00);
      bad0 = 0; bad1 = 0; badp = 0;
      for (int k = 0; k < 300 && !periodStart; k++) begin
         if (out_pwm[0] !== 1'b0) bad0++;
         if (out_pwm[1] !== 1'b1) bad1++;
         if (pending !== 1'b1) badp++;
         @(negedge clock);
      end
      chk("shadow_hold0", bad0, 0);
      chk("shadow_hold1", bad1, 0);
      chk("shadow_pend_hi", badp, 0);
      chk("shadow_ps", periodStart, 1);
      chk("shadow_ud", updateDone, 1);
      measure(256);
      chk("shadow_last_hi0", hi0, 10);
      chk("shadow_last_rise0", fh0, 31);
      chk("shadow_last_hi1", hi1, 45);
   endtask

   task automatic test_period;
      do_load(8'd99, 8'd10, 8'd20, 8'd0, 8'd0, 2'b00);
      wait_ps(300);
      chk("period_apply_wait", waited, 255);
      wait_ps(300);
      chk("period_100", waited, 100);
      skip(99);
      chk("coinc_pre_pend", pending, 0);
      do_load(8'd99, 8'd5, 8'd15, 8'd0, 8'd50, 2'b10);
      chk("coinc_ps", periodStart, 1);
      chk("coinc_ud", updateDone, 1);
      chk("coinc_pend", pending, 0);
      measure(100);
      chk("coinc_hi0", hi0, 10);
      chk("coinc_rise0", fh0, 6);
      chk("coinc_hi1", hi1, 50);
      chk("coinc_rise1", fh1, 51);
      chk("coinc_ps_next", periodStart, 1);
   endtask

   task automatic test_enable;
      int bad, highs;
      skip(10);
      chk("en_mid_pulse", out_pwm, 2'b01);
      enable = 1'b0;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (out_pwm !== 2'b10 || periodStart !== 1'b0) bad++;
      end
      chk("en_idle_level", bad, 0);
      enable = 1'b1;
      @(negedge clock);
      chk("en_resume_out", out_pwm, 2'b01);
      highs = 1;
      waited = 1;
      while (!periodStart && waited < 200) begin
         @(negedge clock);
         waited++;
         if (out_pwm[0]) highs++;
      end
      chk("en_resume_len", waited, 90);
      chk("en_resume_hi0", highs, 5);
   endtask

   task automatic test_async_reset;
      do_load(8'd255, 8'd0, 8'd50, 8'd0, 8'd50, 2'b11);
      skip(59);
      chk("rst_pre_pend", pending, 1);
      chk("rst_pre_out1", out_pwm[1], 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_out", out_pwm, 2'b00);
      chk("rst_async_pend", pending, 0);
      @(negedge clock);
      reset = 1'b0;
      skip(3);
      chk("rst_post_ps", periodStart, 1);
      chk("rst_post_out", out_pwm, 2'b00);
      chk("rst_post_pend", pending, 0);
      chk("rst_post_ud", updateDone, 0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b1;
      test_reset();
      test_basic();
      test_wrap();
      test_corner();
      test_shadow();
      test_period();
      test_enable();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
